// File: rtl/shift_ctrl_if.sv
// Request, shared-shifter and result channels of the shift sequencer.
// slave = sequencer side, master = requesters, shifter and result consumer.
interface shift_ctrl_if;
  localparam int unsigned DW = 8;
  localparam int unsigned AW = 3;

  logic          r0_valid;
  logic          r0_ready;
  logic [1:0]    r0_op;
  logic [AW-1:0] r0_amt;
  logic [DW-1:0] r0_data;
  logic          r1_valid;
  logic          r1_ready;
  logic [1:0]    r1_op;
  logic [AW-1:0] r1_amt;
  logic [DW-1:0] r1_data;
  logic [DW-1:0] sh_ip;
  logic [AW-1:0] sh_s;
  logic [DW-1:0] sh_out;
  logic          res_valid;
  logic          res_ready;
  logic [DW-1:0] res_data;
  logic          res_tag;
  logic          busy;

  modport slave (
    input  r0_valid, r0_op, r0_amt, r0_data,
    input  r1_valid, r1_op, r1_amt, r1_data,
    input  sh_out, res_ready,
    output r0_ready, r1_ready, sh_ip, sh_s,
    output res_valid, res_data, res_tag, busy
  );

  modport master (
    output r0_valid, r0_op, r0_amt, r0_data,
    output r1_valid, r1_op, r1_amt, r1_data,
    output sh_out, res_ready,
    input  r0_ready, r1_ready, sh_ip, sh_s,
    input  res_valid, res_data, res_tag, busy
  );
endinterface

// File: rtl/shift_ctrl.sv
// Round-robin sequencer for the shared 8-bit left barrel shifter: right shifts
// via bit reversal, rotates as two ORed shifter passes.
module shift_ctrl (
  input  logic        clk,
  input  logic        rst_n,
  shift_ctrl_if.slave bus
);
  localparam int unsigned DW = 8;
  localparam int unsigned AW = 3;
  localparam int unsigned SW = AW + 1;
  localparam logic [1:0] OP_SLL = 2'd0;
  localparam logic [1:0] OP_SRL = 2'd1;
  localparam logic [1:0] OP_ROR = 2'd3;

  typedef enum logic [1:0] {IDLE, P1, P2, DONE} state_e;

  state_e        state_q, state_d;
  logic [1:0]    op_q, op_d;
  logic [AW-1:0] amt_q, amt_d;
  logic [DW-1:0] data_q, data_d;
  logic [DW-1:0] acc_q, acc_d;
  logic          tag_q, tag_d;
  logic          last_grant_q, last_grant_d;
  logic [DW-1:0] sh_ip_q, sh_ip_d;
  logic [AW-1:0] sh_s_q, sh_s_d;
  logic          res_valid_q, res_valid_d;
  logic [DW-1:0] res_data_q, res_data_d;
  logic          res_tag_q, res_tag_d;
  logic          busy_q, busy_d;

  logic          grant0_c, grant1_c, idle_c, accept_c, two_pass_c;
  logic [1:0]    in_op_c;
  logic [AW-1:0] in_amt_c;
  logic [DW-1:0] in_data_c;

  function automatic logic [DW-1:0] rev8(input logic [DW-1:0] x);
    logic [DW-1:0] r;
    for (int i = 0; i < int'(DW); i++) r[i] = x[DW-1-i];
    return r;
  endfunction

  // 8 - a in 4 bits, truncated to 3; only used with a in 1..7.
  function automatic logic [AW-1:0] comp8(input logic [AW-1:0] a);
    logic [SW-1:0] w;
    w = SW'(DW) - {1'b0, a};
    return w[AW-1:0];
  endfunction

  // First-pass left amount: ROR n becomes ROL 8-n, amount 0 stays 0.
  function automatic logic [AW-1:0] pass1_amt(input logic [1:0] op, input logic [AW-1:0] amt);
    return (op == OP_ROR && amt != '0) ? comp8(amt) : amt;
  endfunction

  // Winner: sole requester, else the one that did not win last time.
  assign grant0_c  = bus.r0_valid & (~bus.r1_valid | last_grant_q);
  assign grant1_c  = bus.r1_valid & ~grant0_c;
  assign idle_c    = (state_q == IDLE);
  assign accept_c  = idle_c & (grant0_c | grant1_c);
  assign in_op_c   = grant1_c ? bus.r1_op   : bus.r0_op;
  assign in_amt_c  = grant1_c ? bus.r1_amt  : bus.r0_amt;
  assign in_data_c = grant1_c ? bus.r1_data : bus.r0_data;
  assign two_pass_c = op_q[1] & (amt_q != '0);

  assign bus.r0_ready  = rst_n & idle_c & grant0_c;
  assign bus.r1_ready  = rst_n & idle_c & grant1_c;
  assign bus.sh_ip     = sh_ip_q;
  assign bus.sh_s      = sh_s_q;
  assign bus.res_valid = res_valid_q;
  assign bus.res_data  = res_data_q;
  assign bus.res_tag   = res_tag_q;
  assign bus.busy      = busy_q;

  // Next state; shifter operands are registered one cycle ahead of their pass.
  always_comb begin
    state_d      = state_q;
    op_d         = op_q;
    amt_d        = amt_q;
    data_d       = data_q;
    acc_d        = acc_q;
    tag_d        = tag_q;
    last_grant_d = last_grant_q;
    sh_ip_d      = '0;
    sh_s_d       = '0;
    res_valid_d  = res_valid_q;
    res_data_d   = res_data_q;
    res_tag_d    = res_tag_q;
    case (state_q)
      IDLE: begin
        if (accept_c) begin
          op_d         = in_op_c;
          amt_d        = in_amt_c;
          data_d       = in_data_c;
          tag_d        = grant1_c;
          last_grant_d = grant1_c;
          sh_ip_d      = (in_op_c == OP_SRL) ? rev8(in_data_c) : in_data_c;
          sh_s_d       = pass1_amt(in_op_c, in_amt_c);
          state_d      = P1;
        end
      end
      P1: begin
        acc_d = (op_q == OP_SRL) ? rev8(bus.sh_out) : bus.sh_out;
        if (two_pass_c) begin
          sh_ip_d = rev8(data_q);
          sh_s_d  = comp8(pass1_amt(op_q, amt_q));
          state_d = P2;
        end else begin
          res_valid_d = 1'b1;
          res_data_d  = acc_d;
          res_tag_d   = tag_q;
          state_d     = DONE;
        end
      end
      P2: begin
        acc_d       = acc_q | rev8(bus.sh_out);
        res_valid_d = 1'b1;
        res_data_d  = acc_d;
        res_tag_d   = tag_q;
        state_d     = DONE;
      end
      DONE: begin
        if (bus.res_ready) begin
          res_valid_d = 1'b0;
          state_d     = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      op_q         <= OP_SLL;
      amt_q        <= '0;
      data_q       <= '0;
      acc_q        <= '0;
      tag_q        <= 1'b0;
      last_grant_q <= 1'b1;
      sh_ip_q      <= '0;
      sh_s_q       <= '0;
      res_valid_q  <= 1'b0;
      res_data_q   <= '0;
      res_tag_q    <= 1'b0;
      busy_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      op_q         <= op_d;
      amt_q        <= amt_d;
      data_q       <= data_d;
      acc_q        <= acc_d;
      tag_q        <= tag_d;
      last_grant_q <= last_grant_d;
      sh_ip_q      <= sh_ip_d;
      sh_s_q       <= sh_s_d;
      res_valid_q  <= res_valid_d;
      res_data_q   <= res_data_d;
      res_tag_q    <= res_tag_d;
      busy_q       <= busy_d;
    end
  end
endmodule

// File: doc/shift_ctrl.md
# shift_ctrl

Sequencer and arbiter for the shared 8-bit barrel left shifter in the execute stage. It accepts shift and rotate requests from two requesters (r0: ALU issue, r1: address/immediate unit) and grants them round-robin. Right shifts are built from bit-reversal around the left shifter, and rotates from two shifter passes ORed together. The result is returned on a valid/ready output channel tagged with the requester ID.

## Interface
- No parameters; data width is fixed at 8 and the shift amount at 3 bits.
- clk  in  1  single clock; all state updates on the rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- r0_valid, r1_valid  in  1  request present.
- r0_ready, r1_ready  out  1  request accepted this cycle (combinational).
- r0_op, r1_op  in  2  operation: 00 SLL, 01 SRL, 10 ROL, 11 ROR.
- r0_amt, r1_amt  in  3  shift/rotate amount, 0..7.
- r0_data, r1_data  in  8  operand.
- sh_ip  out  8  operand to the shared shifter.
- sh_s  out  3  shift amount to the shared shifter.
- sh_out  in  8  shifter result; combinational, same cycle.
- res_valid  out  1  result available.
- res_ready  in  1  consumer accepts the result.
- res_data  out  8  result.
- res_tag  out  1  ID of the requester that owns the result (0/1).
- busy  out  1  high in every state except IDLE.

## Operation
- Reset values: every output register is 0. res_valid, res_data, res_tag, busy, sh_ip and sh_s are 0. State is IDLE and last_grant is 1, so r0 wins the first contention.
- States: IDLE, P1, P2, DONE.
- IDLE
  - Winner selection:
    - Only one valid: that requester wins.
    - Both valid: the requester that is not last_grant wins.
  - rX_ready is asserted to the winner only; ready is never high outside IDLE.
  - On acceptance, latch op, amt, data and tag; set last_grant to the tag; go to P1.
- Pass plan (rev() is 8-bit bit reversal):
  - SLL n: P1 computes sh_ip=data, sh_s=n, acc=sh_out. Single pass.
  - SRL n: P1 computes sh_ip=rev(data), sh_s=n, acc=rev(sh_out). Single pass.
  - ROL k with k≠0:
    - P1 computes acc=data<<k.
    - P2 computes sh_ip=rev(data), sh_s=8−k, acc=acc | rev(sh_out).
  - ROR n with n≠0: treated as ROL with k=8−n (both passes).
  - ROL/ROR with amount 0: single pass with sh_s=0, so acc=data.
- Transitions:
  - P1 goes to P2 when a second pass is needed, otherwise to DONE.
  - P2 goes to DONE.
  - DONE holds res_valid=1, res_data=acc and res_tag constant until res_ready=1, then goes to IDLE. res_valid falls on the next cycle.
- Outside P1/P2, sh_ip=0 and sh_s=0. The shifter is never driven by two requesters at once.
- A requester that is not granted keeps its request valid; a dropped request is never queued.
- Width rule: 8−k is computed in 4 bits and truncated to 3. This is legal because k∈1..7.

## Timing
- Acceptance occurs in cycle T (IDLE, valid & ready).
- Single-pass ops: P1 in T+1; res_valid=1 in T+2.
- Two-pass ops (rotate, amount≠0): P1 in T+1, P2 in T+2; res_valid=1 in T+3.
- The earliest next acceptance is the cycle after the DONE handshake. No overlap, so maximum throughput is one op per 3 or 4 cycles.
- Backpressure: while res_ready=0, DONE holds indefinitely with outputs stable and no new grants.
- Async reset asserted mid-operation:
  - The state returns to IDLE immediately and any pending result is discarded; no res_valid follows.
  - last_grant returns to 1.
  - Requests arriving during reset are not accepted.
- Reset release: first acceptance is possible on the first clock edge with rst_n=1.

## Test plan
- SLL: r0 sends SLL 0x81 by 1 → r0_ready in T; res_valid in T+2; res_data=0x02; res_tag=0.
- SRL and rotates:
  - r1 sends SRL 0x80 by 7 → res_data=0x01 in T+2.
  - ROL 0x81 by 1 → res_data=0x03 in T+3.
  - ROR 0x01 by 1 → res_data=0x80 in T+3.
- Zero amounts: ROL 0xA5 by 0 and SLL 0xA5 by 0 → both return 0xA5 with single-pass latency (T+2).
- Contention: r0 and r1 both valid from reset, both holding → grants alternate r0, r1, r0; res_tag sequence 0,1,0; the non-granted ready stays 0.
- Backpressure: hold res_ready=0 for 5 cycles in DONE → res_valid, res_data and res_tag stay stable; busy=1; no rX_ready. Release → exactly one result is consumed.
- Reset mid-op: assert rst_n=0 during P2 of a ROL → all outputs go to 0 asynchronously; no res_valid after release; the next contention grants r0.
